// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD combinational read ports, one synchronous write port, and a soft-clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       LE,
    input  logic [ADDR_W-1:0]          Rc,
    input  logic [DATA_W-1:0]          I,
    input  logic [NUM_RD*ADDR_W-1:0]   Ra,
    output logic [NUM_RD*DATA_W-1:0]   Y,
    input  logic                       soft_clr,
    output logic                       busy,
    output logic                       done,
    output logic                       wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_en;

    // Writes are locked out for the whole sweep so the clear can't be undone mid-flight.
    assign wr_en = !LE && !busy_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wr_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (soft_clr) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                busy_d    = 1'b1;
                wr_drop_d = !LE;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // NOTE: the array is built from flops with an async reset, since a hard reset must zero every register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == SWEEP) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[Rc] <= I;
        end
    end

    always_comb begin
        Y = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            Y[k*DATA_W +: DATA_W] = mem_q[Ra[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (Ra[k*ADDR_W +: ADDR_W] == Rc)) begin
                Y[k*DATA_W +: DATA_W] = I;
            end
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized traffic against an array model.
module tb_regfile_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     clr;
    logic                     LE;
    logic [ADDR_W-1:0]        Rc;
    logic [DATA_W-1:0]        I;
    logic [NUM_RD*ADDR_W-1:0] Ra;
    logic [NUM_RD*DATA_W-1:0] Y;
    logic                     soft_clr;
    logic                     busy;
    logic                     done;
    logic                     wr_drop;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] model [DEPTH];

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .clr(clr), .LE(LE), .Rc(Rc), .I(I), .Ra(Ra), .Y(Y),
        .soft_clr(soft_clr), .busy(busy), .done(done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] y_of(int k);
        return Y[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_ra(int k, logic [ADDR_W-1:0] a);
        Ra[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic write_reg(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        LE = 1'b0; Rc = a; I = d;
        step();
        LE = 1'b1;
        model[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic check_all_zero(string tag);
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(0, ADDR_W'(a));
            set_ra(1, ADDR_W'(DEPTH - 1 - a));
            #1;
            n_tests++;
            if (y_of(0) !== '0 || y_of(1) !== '0) begin
                n_fail++;
                $display("FAIL %s addr=%0d got y0=%h y1=%h exp 0", tag, a, y_of(0), y_of(1));
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; LE = 1'b1; soft_clr = 1'b0; Rc = '0; I = '0; Ra = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got busy=%b done=%b wr_drop=%b exp 0/0/0", busy, done, wr_drop);
        end
        check_all_zero("reset_read");
    endtask

    task automatic test_write_read();
        write_reg(4'd5, 32'hDEAD_BEEF);
        set_ra(0, 4'd5); set_ra(1, 4'd5);
        #1;
        n_tests++;
        if (y_of(0) !== 32'hDEAD_BEEF || y_of(1) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_read got y0=%h y1=%h exp deadbeef", y_of(0), y_of(1));
        end
        LE = 1'b1; Rc = 4'd5; I = 32'h1234_5678;
        step();
        n_tests++;
        if (y_of(0) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_disabled got %h exp deadbeef", y_of(0));
        end
    endtask

    task automatic test_sweep();
        for (int n = 0; n < DEPTH; n++) write_reg(ADDR_W'(n), 32'h100 + n);
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_busy cycle=%0d got busy=%b done=%b exp 1/0", i, busy, done);
            end
            if (i == 4) begin
                set_ra(0, 4'd3); set_ra(1, 4'd10);
                #1;
                n_tests++;
                if (y_of(0) !== '0 || y_of(1) !== 32'h10A) begin
                    n_fail++;
                    $display("FAIL sweep_mid got r3=%h r10=%h exp 0/10a", y_of(0), y_of(1));
                end
            end
            step();
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_done got busy=%b done=%b exp 0/1", busy, done);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done_pulse got done=%b exp 0", done);
        end
        clear_model();
        check_all_zero("sweep_clear");
    endtask

    task automatic test_write_during_sweep();
        write_reg(4'd2, 32'hAAAA);
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) begin
                LE = 1'b0; Rc = 4'd2; I = 32'h55; set_ra(1, 4'd2);
                #1;
                n_tests++;
                if (y_of(1) !== '0) begin
                    n_fail++;
                    $display("FAIL sweep_no_forward got %h exp 0", y_of(1));
                end
            end
            if (i == 6) begin
                LE = 1'b1;
                n_tests++;
                if (wr_drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_drop_pulse got %b exp 1", wr_drop);
                end
            end
            if (i == 7) begin
                n_tests++;
                if (wr_drop !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_drop_end got %b exp 0", wr_drop);
                end
            end
            soft_clr = (i == 8);
            step();
        end
        soft_clr = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep2_done got busy=%b done=%b exp 0/1", busy, done);
        end
        set_ra(1, 4'd2);
        #1;
        n_tests++;
        if (y_of(1) !== '0) begin
            n_fail++;
            $display("FAIL dropped_write got r2=%h exp 0", y_of(1));
        end
        LE = 1'b0; Rc = 4'd2; I = 32'h55; soft_clr = 1'b1;
        step();
        LE = 1'b1; soft_clr = 1'b0;
        clear_model();
        model[2] = 32'h55;
        n_tests++;
        if (y_of(1) !== 32'h55 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_write got r2=%h busy=%b exp 55/0", y_of(1), busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        write_reg(4'd1, 32'h11); write_reg(4'd14, 32'hEE);
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        repeat (7) step();
        clr = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_status got busy=%b done=%b exp 0/0", busy, done);
        end
        step();
        clr = 1'b1;
        clear_model();
        check_all_zero("rst_mid_clear");
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done got %0d active cycles exp 0", done_seen);
        end
        write_reg(4'd7, 32'h77);
        set_ra(0, 4'd7);
        #1;
        n_tests++;
        if (y_of(0) !== 32'h77) begin
            n_fail++;
            $display("FAIL rst_mid_write got %h exp 77", y_of(0));
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp;
        write_reg(4'd9, 32'h11);
        LE = 1'b0; Rc = 4'd9; I = 32'h22; set_ra(0, 4'd9);
        #1;
        exp = BYP ? 32'h22 : 32'h11;
        n_tests++;
        if (y_of(0) !== exp) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got %h exp %h", y_of(0), exp);
        end
        step();
        LE = 1'b1;
        model[9] = 32'h22;
        n_tests++;
        if (y_of(0) !== 32'h22) begin
            n_fail++;
            $display("FAIL bypass_next_cycle got %h exp 22", y_of(0));
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < 300; t++) begin
            LE = ($urandom_range(0, 2) == 0);
            Rc = ADDR_W'($urandom);
            I  = $urandom;
            Ra = (NUM_RD*ADDR_W)'($urandom);
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                a = Ra[k*ADDR_W +: ADDR_W];
                exp = (BYP && !LE && a == Rc) ? I : model[a];
                n_tests++;
                if (y_of(k) !== exp) begin
                    n_fail++;
                    $display("FAIL random_read t=%0d port=%0d addr=%0d got %h exp %h", t, k, a, y_of(k), exp);
                end
            end
            step();
            if (!LE) model[Rc] = I;
        end
        LE = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_write_during_sweep();
        test_reset_mid_sweep();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
